// File: rtl/pc_stack_unit.sv
// pc_stack_unit: program counter for the PicoMIPS core with a LIFO return stack.
// It handles increment, conditional relative branch, subroutine call/return and interrupt entry.
// Latency: 1 cycle. A command sampled at an edge is visible on pc/depth right after that edge.
// Backpressure: en=0 stalls. All state holds and the command inputs are ignored.
//
// Ports:
//   clk, rst           clock and synchronous active-high reset
//   en                 advance enable (0 = stall)
//   mode               0=RETURN 1=INCREMENT 2=RELATIVE 3=SUBROUTINE
//   take               branch condition for RELATIVE
//   imm                signed offset (RELATIVE) or unsigned target (SUBROUTINE)
//   irq                level interrupt request, sampled only while en=1
//   pc                 registered program counter
//   depth              registered stack occupancy
//   overflow/underflow sticky stack-error flags, cleared only by rst
module pc_stack_unit #(
  parameter int unsigned A       = 10,
  parameter int unsigned IMM_W   = 8,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned RST_VEC = 0,
  parameter int unsigned IRQ_VEC = 1,
  localparam int unsigned DW     = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic             take,
  input  logic [IMM_W-1:0] imm,
  input  logic             irq,
  output logic [A-1:0]     pc,
  output logic [DW-1:0]    depth,
  output logic             overflow,
  output logic             underflow
);

  localparam logic [1:0] MODE_RETURN     = 2'd0;
  localparam logic [1:0] MODE_INCREMENT  = 2'd1;
  localparam logic [1:0] MODE_RELATIVE   = 2'd2;
  localparam logic [1:0] MODE_SUBROUTINE = 2'd3;

  // Stack index width. Stack positions 0..DEPTH-1 always fit in IW bits.
  localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // Width that holds both the immediate and the PC, used for extension before truncation.
  localparam int unsigned EW = (A > IMM_W) ? A : IMM_W;

  logic [A-1:0]  stack [0:DEPTH-1];

  logic [A-1:0]  pc_nxt;
  logic [DW-1:0] depth_nxt;
  logic          overflow_nxt;
  logic          underflow_nxt;
  logic          push;

  logic [A-1:0]  pc_inc;
  logic [EW-1:0] imm_sx;
  logic [EW-1:0] imm_zx;
  logic [IW-1:0] wr_idx;
  logic [IW-1:0] rd_idx;
  logic          full;

  assign pc_inc = pc + A'(1);
  assign imm_sx = EW'($signed(imm));
  assign imm_zx = EW'(imm);
  assign full   = (depth == DW'(DEPTH));
  // A push writes entry [depth]. A pop reads entry [depth-1].
  // The low-bit subtraction is exact because depth never exceeds 2**IW.
  assign wr_idx = depth[IW-1:0];
  assign rd_idx = wr_idx - IW'(1);

  always_comb begin
    pc_nxt        = pc;
    depth_nxt     = depth;
    overflow_nxt  = overflow;
    underflow_nxt = underflow;
    push          = 1'b0;

    if (en) begin
      if (irq) begin
        // Interrupt entry saves the address after the current instruction.
        // This lets RETURN resume past a WFI.
        pc_nxt = A'(IRQ_VEC);
        if (full) begin
          overflow_nxt = 1'b1;
        end else begin
          push      = 1'b1;
          depth_nxt = depth + DW'(1);
        end
      end else begin
        case (mode)
          MODE_INCREMENT: begin
            pc_nxt = pc_inc;
          end
          MODE_RELATIVE: begin
            pc_nxt = take ? (pc + imm_sx[A-1:0]) : pc_inc;
          end
          MODE_SUBROUTINE: begin
            // The jump happens even when the stack is full. Only the save is lost.
            pc_nxt = imm_zx[A-1:0];
            if (full) begin
              overflow_nxt = 1'b1;
            end else begin
              push      = 1'b1;
              depth_nxt = depth + DW'(1);
            end
          end
          MODE_RETURN: begin
            if (depth != '0) begin
              pc_nxt    = stack[rd_idx];
              depth_nxt = depth - DW'(1);
            end else begin
              // Returning from an empty stack is flagged and falls through.
              underflow_nxt = 1'b1;
              pc_nxt        = pc_inc;
            end
          end
          default: begin
            pc_nxt = pc;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc        <= A'(RST_VEC);
      depth     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      pc        <= pc_nxt;
      depth     <= depth_nxt;
      overflow  <= overflow_nxt;
      underflow <= underflow_nxt;
    end
  end

  // Stack storage has no reset. An empty stack is defined by depth alone.
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      stack[wr_idx] <= pc_inc;
    end
  end

endmodule

// File: tb/tb_pc_stack_unit.sv
module tb_pc_stack_unit;

  localparam int A     = 10;
  localparam int IMM_W = 8;
  localparam int DEPTH = 4;
  localparam int DW    = $clog2(DEPTH + 1);

  localparam logic [1:0] RET = 2'd0;
  localparam logic [1:0] INC = 2'd1;
  localparam logic [1:0] REL = 2'd2;
  localparam logic [1:0] SUB = 2'd3;

  logic             clk = 1'b0;
  logic             rst;
  logic             en;
  logic [1:0]       mode;
  logic             take;
  logic [IMM_W-1:0] imm;
  logic             irq;
  logic [A-1:0]     pc;
  logic [DW-1:0]    depth;
  logic             overflow;
  logic             underflow;

  typedef struct packed {
    logic [A-1:0]  pc;
    logic [DW-1:0] depth;
    logic          ovf;
    logic          unf;
  } exp_t;

  typedef struct {
    exp_t  e;
    string name;
  } item_t;

  item_t exp_q[$];
  int    checks = 0;
  int    errors = 0;
  int    step_no = 0;

  always #5 clk = ~clk;

  pc_stack_unit #(
    .A(A), .IMM_W(IMM_W), .DEPTH(DEPTH), .RST_VEC(0), .IRQ_VEC(1)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .take(take), .imm(imm), .irq(irq),
    .pc(pc), .depth(depth), .overflow(overflow), .underflow(underflow)
  );

  // Drive one command and queue its hand-computed result for the following edge.
  task automatic step(input string name, input logic r, input logic e, input logic [1:0] m,
                      input logic t, input logic [IMM_W-1:0] im, input logic iq,
                      input logic [A-1:0] epc, input int edep, input logic eovf, input logic eunf);
    item_t it;
    @(posedge clk);
    #1;
    rst  = r;
    en   = e;
    mode = m;
    take = t;
    imm  = im;
    irq  = iq;
    it.e.pc    = epc;
    it.e.depth = DW'(edep);
    it.e.ovf   = eovf;
    it.e.unf   = eunf;
    it.name    = $sformatf("%0d_%s", step_no, name);
    step_no++;
    exp_q.push_back(it);
  endtask

  // Monitor. Each edge consumes the command driven before it, so pop at the edge and compare
  // once the registers have settled.
  initial begin
    item_t it;
    exp_t  act;
    forever begin
      @(posedge clk);
      if (exp_q.size() > 0) begin
        it = exp_q.pop_front();
        #3;
        act = '{pc: pc, depth: depth, ovf: overflow, unf: underflow};
        checks++;
        if (act !== it.e) begin
          errors++;
          $display("FAIL %s: got pc=%h depth=%0d ovf=%b unf=%b, expected pc=%h depth=%0d ovf=%b unf=%b",
                   it.name, act.pc, act.depth, act.ovf, act.unf,
                   it.e.pc, it.e.depth, it.e.ovf, it.e.unf);
        end
      end
    end
  end

  initial begin
    rst = 1'b1; en = 1'b0; mode = INC; take = 1'b0; imm = '0; irq = 1'b0;

    // Reset, then increment
    step("reset",   1, 0, INC, 0, 8'h00, 0, 10'h000, 0, 0, 0);
    step("inc1",    0, 1, INC, 0, 8'h00, 0, 10'h001, 0, 0, 0);
    step("inc2",    0, 1, INC, 0, 8'h00, 0, 10'h002, 0, 0, 0);
    step("inc3",    0, 1, INC, 0, 8'h00, 0, 10'h003, 0, 0, 0);
    step("inc4",    0, 1, INC, 0, 8'h00, 0, 10'h004, 0, 0, 0);
    step("inc5",    0, 1, INC, 0, 8'h00, 0, 10'h005, 0, 0, 0);
    // Relative branches
    step("rel_m2",  0, 1, REL, 1, 8'hFE, 0, 10'h003, 0, 0, 0);
    step("rel_p2",  0, 1, REL, 1, 8'h02, 0, 10'h005, 0, 0, 0);
    step("rel_nt",  0, 1, REL, 0, 8'hFE, 0, 10'h006, 0, 0, 0);
    step("rel_0",   0, 1, REL, 1, 8'h00, 0, 10'h006, 0, 0, 0);
    step("reset2",  1, 1, INC, 0, 8'h00, 0, 10'h000, 0, 0, 0);
    step("rel_m1",  0, 1, REL, 1, 8'hFF, 0, 10'h3FF, 0, 0, 0);
    step("inc_wrap",0, 1, INC, 0, 8'h00, 0, 10'h000, 0, 0, 0);
    step("rel_m16", 0, 1, REL, 1, 8'hF0, 0, 10'h3F0, 0, 0, 0);
    step("rel_wrap",0, 1, REL, 1, 8'h7F, 0, 10'h06F, 0, 0, 0);
    // Nested calls and overflow
    step("reset3",  1, 1, INC, 0, 8'h00, 0, 10'h000, 0, 0, 0);
    step("to_10",   0, 1, REL, 1, 8'h10, 0, 10'h010, 0, 0, 0);
    step("call1",   0, 1, SUB, 0, 8'h40, 0, 10'h040, 1, 0, 0);
    step("call2",   0, 1, SUB, 0, 8'h50, 0, 10'h050, 2, 0, 0);
    step("call3",   0, 1, SUB, 0, 8'h60, 0, 10'h060, 3, 0, 0);
    step("call4",   0, 1, SUB, 0, 8'h70, 0, 10'h070, 4, 0, 0);
    step("call_ovf",0, 1, SUB, 0, 8'h80, 0, 10'h080, 4, 1, 0);
    step("ret1",    0, 1, RET, 0, 8'h00, 0, 10'h061, 3, 1, 0);
    step("ret2",    0, 1, RET, 0, 8'h00, 0, 10'h051, 2, 1, 0);
    step("ret3",    0, 1, RET, 0, 8'h00, 0, 10'h041, 1, 1, 0);
    step("ret4",    0, 1, RET, 0, 8'h00, 0, 10'h011, 0, 1, 0);
    step("ret_unf", 0, 1, RET, 0, 8'h00, 0, 10'h012, 0, 1, 1);
    // Underflow after reset
    step("reset4",  1, 1, INC, 0, 8'h00, 0, 10'h000, 0, 0, 0);
    step("unf",     0, 1, RET, 0, 8'h00, 0, 10'h001, 0, 0, 1);
    step("unf_hold",0, 1, INC, 0, 8'h00, 0, 10'h002, 0, 0, 1);
    // Interrupt and stall (mode is unknown while stalled)
    step("reset5",  1, 1, INC, 0, 8'h00, 0, 10'h000, 0, 0, 0);
    step("to_20",   0, 1, REL, 1, 8'h20, 0, 10'h020, 0, 0, 0);
    step("stall1",  0, 0, 2'bxx, 1, 8'h55, 1, 10'h020, 0, 0, 0);
    step("stall2",  0, 0, 2'bxx, 0, 8'h55, 1, 10'h020, 0, 0, 0);
    step("stall3",  0, 0, SUB, 1, 8'h55, 1, 10'h020, 0, 0, 0);
    step("irq_win", 0, 1, SUB, 0, 8'h55, 1, 10'h001, 1, 0, 0);
    step("irq_ret", 0, 1, RET, 0, 8'h00, 0, 10'h021, 0, 0, 0);
    // Reset mid-subroutine
    step("call_a",  0, 1, SUB, 0, 8'h30, 0, 10'h030, 1, 0, 0);
    step("stall_r", 0, 0, RET, 0, 8'h00, 0, 10'h030, 1, 0, 0);
    step("call_b",  0, 1, SUB, 0, 8'h40, 0, 10'h040, 2, 0, 0);
    step("rst_mid", 1, 1, RET, 0, 8'h00, 0, 10'h000, 0, 0, 0);
    step("ret_post",0, 1, RET, 0, 8'h00, 0, 10'h001, 0, 0, 1);
    // Interrupt entry while the stack is full still jumps and flags overflow
    step("c1",      0, 1, SUB, 0, 8'h11, 0, 10'h011, 1, 0, 1);
    step("c2",      0, 1, SUB, 0, 8'h22, 0, 10'h022, 2, 0, 1);
    step("c3",      0, 1, SUB, 0, 8'h33, 0, 10'h033, 3, 0, 1);
    step("c4",      0, 1, SUB, 0, 8'h44, 0, 10'h044, 4, 0, 1);
    step("irq_full",0, 1, INC, 0, 8'h00, 1, 10'h001, 4, 1, 1);
    step("ret_full",0, 1, RET, 0, 8'h00, 0, 10'h034, 3, 1, 1);

    @(posedge clk);
    #1;
    en = 1'b0; irq = 1'b0;
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    #5;
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d results still pending, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/pc_stack_unit.md
Name: pc_stack_unit

Overview:
- Parametrised program-counter unit for the PicoMIPS core. Successor to the single-level INCREMENT/RELATIVE/SUBROUTINE/RETURN PC logic.
- Adds a configurable-depth hardware return stack, conditional relative branching, and an interrupt entry path that pushes the return address.
- Driven by the decoder each cycle. Drives the program-memory address.

Parameters:
A, 10, PC / program-memory address width.
IMM_W, 8, immediate width from instruction word.
DEPTH, 4, return-stack entries (>=1).
RST_VEC, 0, PC value after reset (A bits).
IRQ_VEC, 1, PC loaded on interrupt entry (A bits).

Ports:
clk  in  1  clock; all state on rising edge.
rst  in  1  synchronous reset, active-high.
en  in  1  advance enable; 0 = stall (HALT, WFI, memory wait).
mode  in  2  pico::modePC: RETURN=0, INCREMENT=1, RELATIVE=2, SUBROUTINE=3.
take  in  1  branch condition for RELATIVE (from ALU Zero flag / BEQ/BNE decode).
imm  in  IMM_W  immediate: signed offset (RELATIVE) or unsigned target (SUBROUTINE).
irq  in  1  interrupt request, level, sampled only when en=1.
pc  out  A  current PC, registered.
depth  out  $clog2(DEPTH+1)  current stack occupancy, registered.
overflow  out  1  sticky: push attempted while full.
underflow  out  1  sticky: pop attempted while empty.

Behaviour:
- Reset: rst=1 at a clock edge gives pc=RST_VEC, depth=0, overflow=0, underflow=0. Stack contents are don't-care.
- Reset has priority over everything, including mid-subroutine: the stack is logically emptied.
- All outputs come straight from registers (no combinational input-to-output path). The new PC is visible the cycle after the edge where the command is sampled. Latency is 1 cycle.
- en=0: pc, stack, depth and flags all hold. irq, mode, take and imm are ignored.
- en=1 priority: irq > mode.
- irq=1:
  - push pc+1, then pc=IRQ_VEC.
  - An ISR ends with RETURN (RSBR), which resumes after the interrupted instruction, including after WFI.
- INCREMENT: pc = pc+1, modulo 2^A (0x3FF -> 0x000 at A=10).
- RELATIVE:
  - take=1: pc = pc + sign-extended imm, modulo 2^A. The offset is relative to the current pc.
  - take=0: pc = pc+1.
  - imm=0 with take=1 is a legal self-loop.
- SUBROUTINE:
  - push pc+1 (mod 2^A), then pc = imm zero-extended to A.
  - If IMM_W>A, imm is truncated to its low A bits.
- RETURN:
  - depth>0: pop, and pc = popped value.
  - depth==0: underflow<=1, pc = pc+1, depth stays 0.
- Push while depth==DEPTH (full):
  - No write and depth unchanged.
  - overflow<=1.
  - The jump (SUBROUTINE target or IRQ_VEC) is still performed.
- Stack is LIFO with a registered pointer; push writes entry [depth], pop reads entry [depth-1]. No simultaneous push and pop exists, since each cycle performs exactly one action.
- overflow and underflow stay set until rst. They never self-clear.
- X/unknown on mode while en=0 must not corrupt state.

Test Plan:
- Reset and increment, A=10, RST_VEC=0: release rst, en=1, mode=INCREMENT for 5 cycles -> pc 0,1,2,3,4,5. Force pc to 0x3FF via SUBROUTINE imm on an IMM_W=10 build, then INCREMENT -> 0x000.
- Relative branch, pc=5, mode=RELATIVE:
  - imm=0xFE, take=1 -> pc=3.
  - Repeat with take=0 -> pc=6.
  - imm=0x7F from pc=0x3F0 -> pc=0x06F (wrap).
- Nested calls, DEPTH=4:
  - From pc=0x10, SUBROUTINE imm=0x40 -> pc=0x40, depth=1.
  - Three more calls -> depth=4.
  - 5th call imm=0x80 -> pc=0x80, depth=4, overflow=1.
  - Four RETURNs -> pcs pop in LIFO order, ending at 0x11, depth=0. overflow stays 1.
- Underflow: after reset, RETURN at pc=0 -> pc=1, underflow=1, depth=0. A further INCREMENT leaves underflow=1.
- Interrupt and stall:
  - pc=0x20, en=0, irq=1 for 3 cycles -> pc holds 0x20.
  - en=1 with irq=1 and mode=SUBROUTINE imm=0x55 -> pc=IRQ_VEC=1, depth=1 (irq wins).
  - irq=0, RETURN -> pc=0x21.
- Reset mid-subroutine: at depth=2, pc=0x40, assert rst for one edge -> pc=0, depth=0, flags 0. A following RETURN raises underflow.
